approx_adder_pipe: RTL and testbench
====================================

# approx_adder_pipe

Pipelined, parametrised N-bit adder with a run-time selectable lower-part-OR approximation over the K least-significant bits and a valid/ready stream interface. It is the streaming successor to the combinational approximate ripple adders: the carry chain is split across STAGES register slices so that approximate and exact additions can be mixed per transaction at full throughput. An optional error monitor compares each approximate result against an exact shadow result. The block sits between operand sources, such as stimulus generators or datapath producers, and result consumers in the approximate-arithmetic evaluation fabric.

## Interface
- `N`, 8 — operand width; must satisfy N % STAGES == 0.
- `STAGES`, 2 — pipeline depth; each stage handles W = N/STAGES bits. STAGES ≥ 1.
- `K`, 3 — approximate LSB count, 0 ≤ K ≤ N. K = 0 makes both modes exact.
- `ERR_W`, 32 — width of the error-sum accumulator.
- `clk` input 1 — clock; all state updates on the rising edge.
- `rstN` input 1 — reset; asynchronous, active-low.
- `inValid` input 1 — operand beat valid.
- `inReady` output 1 — block accepts a beat this cycle.
- `A`, `B` input N — operands, unsigned.
- `mode` input 1 — 1 = approximate, 0 = exact.
- `outValid` output 1 — result beat valid.
- `outReady` input 1 — consumer accepts the result.
- `sum` output N+1 — result; the MSB is the carry-out.
- `outMode` output 1 — the `mode` that travelled with this result.
- `statClr` input 1 — synchronous clear of the statistics.
- `errCount` output 32 — count of approximate results with a nonzero error; saturating.
- `errSum` output ERR_W — sum of absolute error distances; saturating.
- `errMax` output N+1 — maximum absolute error distance seen.

## Operation
- **Exact mode:** `sum` = A + B, the full N+1-bit result.
- **Approximate mode, bit i < K:** s_i = a_i | b_i, and no carry is propagated within the low part.
- **Approximate mode, carry into bit K:** the carry into bit K is a_{K-1} & b_{K-1}.
- **Approximate mode, bits ≥ K:** exact ripple addition; the carry-out of bit N-1 becomes `sum[N]`.
- **Stage slicing:** stage s computes bits [s·W, (s+1)·W). The carry into stage s comes from the stage s-1 register.
- **Skew registers:** operands and sum bits are skew-registered so that the slices belonging to one beat stay aligned. `mode` is pipelined alongside the data.
- **Pipeline control:** the whole pipeline advances when `en = outReady | ~outValid`, and `inReady = en`.
  - A beat is accepted when `inValid & inReady`.
  - When `en` is high and `inValid` is low, a bubble is inserted.
  - Each stage carries its own valid bit.
- **Backpressure:** while `outValid & ~outReady`, every pipeline register holds its value. `sum` and `outMode` are then stable.
- **Ordering:** results leave in acceptance order. No beat is dropped or duplicated.
- **Reset:** all valid bits, data registers and statistics clear to 0, so `inReady` = 1 and `outValid` = 0. A reset mid-operation discards every in-flight beat.

## Timing
- **Latency:** exactly STAGES cycles from an accepting edge to `outValid`, when there are no stalls.
- **Throughput:** one beat per cycle while `outReady` = 1.
- **Stall timing:** `inReady` falls combinationally in the same cycle that `outValid & ~outReady` holds.
- **Statistics timing:** statistics update on the edge on which a beat with `outMode` = 1 transfers (`outValid & outReady`). The updated values are visible in the next cycle.
- **Clear priority:** when `statClr` coincides with a transfer, the clear wins and that beat's contribution is discarded.

## Configuration
- Macro: `APPROX_ERR_STATS_EN`.
- **Defined:**
  - A shadow exact adder is pipelined in lockstep with the main datapath.
  - d = |exact − approx| for each transferred approximate beat.
  - `errCount` increments by 1 when d ≠ 0, saturating at 2^32−1.
  - `errSum` += d, saturating at 2^ERR_W−1.
  - `errMax` = max(`errMax`, d).
- **Undefined:**
  - The shadow adder and statistics logic are not built.
  - `errCount`, `errSum` and `errMax` are tied to 0.
  - `statClr` is ignored.

## Test plan
All scenarios use N=8, STAGES=2, K=3, with `APPROX_ERR_STATS_EN` defined.
- **Exact mode:** A=0x08, B=0x7A, mode=0 → `sum`=0x082 and `outMode`=0, exactly 2 cycles after acceptance.
- **Approximate mode, carry into bit K set:** A=0x0D, B=0x17, mode=1 → `sum`=0x027 (exact 0x024). Then `errCount`=1, `errSum`=3, `errMax`=3.
- **Approximate mode, no carry into bit K:** the next beat A=0x1B, B=0x6E, mode=1 → `sum`=0x087 (exact 0x089). Then `errCount`=2, `errSum`=5, `errMax`=3.
- **Backpressure:**
  - Stimulus: stream 4 mixed-mode beats and hold `outReady`=0 for 3 cycles once `outValid` rises.
  - During the hold: `inReady`=0, and `sum` and `outMode` are unchanged.
  - After release: all 4 results appear in order, with no loss.
- **Reset mid-operation:** assert `rstN`=0 with 2 beats in flight → `outValid`=0 and `inReady`=1 immediately; stats = 0. After release, no stale beat emerges.
- **Statistics clear:**
  - `statClr`=1 on the same edge as an approximate transfer with d=2 → all stats = 0 next cycle.
  - A following beat A=0xFF, B=0xFF, mode=1 → `sum`=0x1FF (exact 0x1FE), `errCount`=1, `errMax`=1.

Source files
------------

// File: rtl/approx_adder_pipe.sv
// Pipelined N-bit adder with a per-beat lower-part-OR approximation and a valid/ready stream.
// Define APPROX_ERR_STATS_EN to build the exact shadow adder and the error statistics.
module approx_adder_pipe #(
    parameter int N      = 8,
    parameter int STAGES = 2,
    parameter int K      = 3,
    parameter int ERR_W  = 32
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             inValid,
    output logic             inReady,
    input  logic [N-1:0]     A,
    input  logic [N-1:0]     B,
    input  logic             mode,
    output logic             outValid,
    input  logic             outReady,
    output logic [N:0]       sum,
    output logic             outMode,
    input  logic             statClr,
    output logic [31:0]      errCount,
    output logic [ERR_W-1:0] errSum,
    output logic [N:0]       errMax
);

    localparam int W = N / STAGES;
    localparam int L = STAGES - 1;

    // Adds the W-bit slice owned by stage stg on top of the partial sum from earlier stages.
    // Returns {carry out of the slice, updated partial sum}.
    function automatic logic [N:0] slice_add(
        input logic [N-1:0] a,
        input logic [N-1:0] b,
        input logic [N-1:0] sum_in,
        input logic         cin,
        input logic         approx,
        input int           stg
    );
        logic [N-1:0] s;
        logic         c;
        int           idx;
        s = sum_in;
        c = cin;
        for (int j = 0; j < W; j++) begin
            idx = stg * W + j;
            if (approx && (idx < K)) begin
                s[idx] = a[idx] | b[idx];
                c      = (idx == K - 1) ? (a[idx] & b[idx]) : 1'b0;
            end else begin
                s[idx] = a[idx] ^ b[idx] ^ c;
                c      = (a[idx] & b[idx]) | (c & (a[idx] ^ b[idx]));
            end
        end
        return {c, s};
    endfunction

    // Stream handshake: a beat moves across an interface on a rising edge where valid and
    // ready are both high; a producer holds valid and data steady until that edge. The whole
    // pipe shifts together on en, so inReady is en and a full, stalled output blocks input.
    logic en;

    logic [N-1:0]      a_q   [STAGES];
    logic [N-1:0]      a_d   [STAGES];
    logic [N-1:0]      b_q   [STAGES];
    logic [N-1:0]      b_d   [STAGES];
    logic [N-1:0]      sum_q [STAGES];
    logic [N-1:0]      sum_d [STAGES];
    logic [STAGES-1:0] c_q, c_d;
    logic [STAGES-1:0] mode_q, mode_d;
    logic [STAGES-1:0] valid_q, valid_d;

    logic [N-1:0]      in_a   [STAGES];
    logic [N-1:0]      in_b   [STAGES];
    logic [N-1:0]      in_sum [STAGES];
    logic [STAGES-1:0] in_c, in_m, in_v;
    logic [N:0]        res    [STAGES];

    assign en       = outReady | ~valid_q[L];
    assign inReady  = en;
    assign outValid = valid_q[L];
    assign outMode  = mode_q[L];
    assign sum      = {c_q[L], sum_q[L]};

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        if (s == 0) begin : g_head
            assign in_a[s]   = A;
            assign in_b[s]   = B;
            assign in_sum[s] = '0;
            assign in_c[s]   = 1'b0;
            assign in_m[s]   = mode;
            assign in_v[s]   = inValid;
        end else begin : g_body
            assign in_a[s]   = a_q[s-1];
            assign in_b[s]   = b_q[s-1];
            assign in_sum[s] = sum_q[s-1];
            assign in_c[s]   = c_q[s-1];
            assign in_m[s]   = mode_q[s-1];
            assign in_v[s]   = valid_q[s-1];
        end
        assign res[s] = slice_add(in_a[s], in_b[s], in_sum[s], in_c[s], in_m[s], s);
    end

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        c_d     = c_q;
        mode_d  = mode_q;
        valid_d = valid_q;
        if (en) begin
            for (int s = 0; s < STAGES; s++) begin
                a_d[s]     = in_a[s];
                b_d[s]     = in_b[s];
                sum_d[s]   = res[s][N-1:0];
                c_d[s]     = res[s][N];
                mode_d[s]  = in_m[s];
                valid_d[s] = in_v[s];
            end
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int s = 0; s < STAGES; s++) begin
                a_q[s]   <= '0;
                b_q[s]   <= '0;
                sum_q[s] <= '0;
            end
            c_q     <= '0;
            mode_q  <= '0;
            valid_q <= '0;
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                a_q[s]   <= a_d[s];
                b_q[s]   <= b_d[s];
                sum_q[s] <= sum_d[s];
            end
            c_q     <= c_d;
            mode_q  <= mode_d;
            valid_q <= valid_d;
        end
    end

`ifdef APPROX_ERR_STATS_EN
    localparam int SW = ((ERR_W > N + 1) ? ERR_W : N + 1) + 1;

    // Shadow exact adder: same slicing and enables, approximation forced off.
    logic [N-1:0]      ex_sum_q  [STAGES];
    logic [N-1:0]      ex_sum_d  [STAGES];
    logic [N-1:0]      ex_in_sum [STAGES];
    logic [STAGES-1:0] ex_c_q, ex_c_d, ex_in_c;
    logic [N:0]        ex_res    [STAGES];

    for (genvar s = 0; s < STAGES; s++) begin : g_shadow
        if (s == 0) begin : g_head
            assign ex_in_sum[s] = '0;
            assign ex_in_c[s]   = 1'b0;
        end else begin : g_body
            assign ex_in_sum[s] = ex_sum_q[s-1];
            assign ex_in_c[s]   = ex_c_q[s-1];
        end
        assign ex_res[s] = slice_add(in_a[s], in_b[s], ex_in_sum[s], ex_in_c[s], 1'b0, s);
    end

    always_comb begin
        ex_sum_d = ex_sum_q;
        ex_c_d   = ex_c_q;
        if (en) begin
            for (int s = 0; s < STAGES; s++) begin
                ex_sum_d[s] = ex_res[s][N-1:0];
                ex_c_d[s]   = ex_res[s][N];
            end
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int s = 0; s < STAGES; s++) begin
                ex_sum_q[s] <= '0;
            end
            ex_c_q <= '0;
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                ex_sum_q[s] <= ex_sum_d[s];
            end
            ex_c_q <= ex_c_d;
        end
    end

    logic [31:0]      err_count_q, err_count_d;
    logic [ERR_W-1:0] err_sum_q, err_sum_d;
    logic [N:0]       err_max_q, err_max_d;
    logic [N:0]       exact_w, dist;
    logic [SW-1:0]    tot;
    logic             xfer;

    assign exact_w = {ex_c_q[L], ex_sum_q[L]};
    assign dist    = (exact_w >= sum) ? (exact_w - sum) : (sum - exact_w);
    assign xfer    = valid_q[L] & outReady & mode_q[L];
    assign tot     = SW'(err_sum_q) + SW'(dist);

    // Clear takes priority over a coinciding transfer.
    always_comb begin
        err_count_d = err_count_q;
        err_sum_d   = err_sum_q;
        err_max_d   = err_max_q;
        if (statClr) begin
            err_count_d = '0;
            err_sum_d   = '0;
            err_max_d   = '0;
        end else if (xfer) begin
            if ((dist != '0) && (err_count_q != '1)) begin
                err_count_d = err_count_q + 32'd1;
            end
            err_sum_d = (tot[SW-1:ERR_W] != '0) ? '1 : tot[ERR_W-1:0];
            if (dist > err_max_q) begin
                err_max_d = dist;
            end
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            err_count_q <= '0;
            err_sum_q   <= '0;
            err_max_q   <= '0;
        end else begin
            err_count_q <= err_count_d;
            err_sum_q   <= err_sum_d;
            err_max_q   <= err_max_d;
        end
    end

    assign errCount = err_count_q;
    assign errSum   = err_sum_q;
    assign errMax   = err_max_q;
`else
    logic unused_stat_clr;
    assign unused_stat_clr = statClr;
    assign errCount        = '0;
    assign errSum          = '0;
    assign errMax          = '0;
`endif

endmodule

// File: tb/tb_approx_adder_pipe.sv
// Randomized and directed bench for approx_adder_pipe against an arithmetic reference model.
module tb_approx_adder_pipe;
  localparam int N      = 8;
  localparam int STAGES = 2;
  localparam int K      = 3;
  localparam int ERR_W  = 32;
  localparam int QW     = 2 * (N + 1) + 1;
`ifdef APPROX_ERR_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk;
  logic             rstN;
  logic             inValid;
  logic             inReady;
  logic [N-1:0]     A;
  logic [N-1:0]     B;
  logic             mode;
  logic             outValid;
  logic             outReady;
  logic [N:0]       sum;
  logic             outMode;
  logic             statClr;
  logic [31:0]      errCount;
  logic [ERR_W-1:0] errSum;
  logic [N:0]       errMax;

  int total = 0;
  int bad   = 0;
  int pops  = 0;

  // scoreboard entry: {mode, exact sum, expected sum}
  logic [QW-1:0]    exp_q[$];
  logic [31:0]      m_cnt;
  logic [ERR_W-1:0] m_sum;
  logic [N:0]       m_max;

  approx_adder_pipe #(.N(N), .STAGES(STAGES), .K(K), .ERR_W(ERR_W)) dut (
    .clk(clk), .rstN(rstN), .inValid(inValid), .inReady(inReady), .A(A), .B(B),
    .mode(mode), .outValid(outValid), .outReady(outReady), .sum(sum), .outMode(outMode),
    .statClr(statClr), .errCount(errCount), .errSum(errSum), .errMax(errMax)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [N:0] ref_add(input logic [N-1:0] a, input logic [N-1:0] b, input logic m);
    int unsigned ai, bi, lo, hi, ck;
    ai = a;
    bi = b;
    if (!m || K == 0) return (N+1)'(ai + bi);
    lo = (ai | bi) & ((1 << K) - 1);
    ck = (ai >> (K - 1)) & (bi >> (K - 1)) & 1;
    hi = ((ai >> K) + (bi >> K) + ck) << K;
    return (N+1)'(hi + lo);
  endfunction

  // scoreboard / stats model, sampled 1 time unit before each rising edge
  always begin
    logic [QW-1:0] item;
    logic [N:0]    ex, ap, d;
    longint        t;
    @(negedge clk);
    #4;
    if (!rstN) begin
      exp_q.delete();
      m_cnt = '0;
      m_sum = '0;
      m_max = '0;
    end else begin
      chk("errCount", 64'(errCount), 64'(m_cnt));
      chk("errSum", 64'(errSum), 64'(m_sum));
      chk("errMax", 64'(errMax), 64'(m_max));
      if (inValid && inReady) exp_q.push_back({mode, ref_add(A, B, 1'b0), ref_add(A, B, mode)});
      if (outValid && outReady) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", 64'(outValid), 64'(0));
        end else begin
          item = exp_q.pop_front();
          pops++;
          chk("sum", 64'(sum), 64'(item[N:0]));
          chk("outMode", 64'(outMode), 64'(item[QW-1]));
          if (STATS && item[QW-1]) begin
            ex = item[2*N+1:N+1];
            ap = item[N:0];
            d  = (ex > ap) ? ex - ap : ap - ex;
            if (d != 0 && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            t = longint'(m_sum) + longint'(d);
            m_sum = (t > longint'({ERR_W{1'b1}})) ? {ERR_W{1'b1}} : ERR_W'(t);
            if (d > m_max) m_max = d;
          end
        end
      end
      if (statClr) begin
        m_cnt = '0;
        m_sum = '0;
        m_max = '0;
      end
    end
  end

  // driver: one beat on an idle pipe; returns at the negedge where the result is valid
  task automatic send_one(input logic [N-1:0] a, input logic [N-1:0] b, input logic m,
                          output logic [N:0] s, output logic om, output int lat);
    @(negedge clk);
    outReady = 1'b1;
    statClr  = 1'b0;
    A        = a;
    B        = b;
    mode     = m;
    inValid  = 1'b1;
    @(negedge clk);
    inValid = 1'b0;
    lat     = 1;
    while (!outValid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    s  = sum;
    om = outMode;
  endtask

  task automatic chk_stats(input string tag, input int c, input int sm, input int mx);
    chk({tag, "_cnt"}, 64'(errCount), STATS ? 64'(c) : 64'(0));
    chk({tag, "_sum"}, 64'(errSum), STATS ? 64'(sm) : 64'(0));
    chk({tag, "_max"}, 64'(errMax), STATS ? 64'(mx) : 64'(0));
  endtask

  initial begin
    logic [N:0] s;
    logic       om;
    int         lat, sent, hold, pops0;
    bit         seen, pend;
    rstN = 1'b0; inValid = 1'b0; A = '0; B = '0; mode = 1'b0; outReady = 1'b1; statClr = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_outValid", 64'(outValid), 64'(0));
    chk("rst_inReady", 64'(inReady), 64'(1));
    chk("rst_sum", 64'(sum), 64'(0));
    chk_stats("rst", 0, 0, 0);
    rstN = 1'b1;

    // exact and approximate directed beats
    send_one(8'h08, 8'h7A, 1'b0, s, om, lat);
    chk("exact_sum", 64'(s), 64'h082);
    chk("exact_mode", 64'(om), 64'(0));
    chk("exact_lat", 64'(lat), 64'(STAGES));
    @(negedge clk);
    send_one(8'h0D, 8'h17, 1'b1, s, om, lat);
    chk("apx1_sum", 64'(s), 64'h027);
    chk("apx1_mode", 64'(om), 64'(1));
    chk("apx1_lat", 64'(lat), 64'(STAGES));
    @(negedge clk);
    chk_stats("apx1", 1, 3, 3);
    send_one(8'h1B, 8'h6E, 1'b1, s, om, lat);
    chk("apx2_sum", 64'(s), 64'h087);
    @(negedge clk);
    chk_stats("apx2", 2, 5, 3);

    // backpressure: 4 mixed beats, output held off for 3 cycles once valid rises
    sent = 0; hold = 0; seen = 0; pend = 0; pops0 = pops;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (outValid && !seen) begin
        seen = 1;
        hold = 3;
      end
      outReady = (hold == 0);
      #1;
      if (hold > 0) begin
        chk("bp_inReady", 64'(inReady), 64'(0));
        if (exp_q.size() != 0) begin
          chk("bp_sum", 64'(sum), 64'(exp_q[0][N:0]));
          chk("bp_mode", 64'(outMode), 64'(exp_q[0][QW-1]));
        end
        hold--;
      end
      if (sent < 4) begin
        if (!pend) begin
          A = 8'($urandom); B = 8'($urandom); mode = sent[0]; pend = 1;
        end
        inValid = 1'b1;
      end else begin
        inValid = 1'b0;
      end
      #1;
      if (inValid && inReady) begin
        sent++;
        pend = 0;
      end
    end
    chk("bp_pops", 64'(pops - pops0), 64'(4));
    chk("bp_empty", 64'(exp_q.size()), 64'(0));

    // reset with two beats in flight
    @(negedge clk);
    outReady = 1'b1; inValid = 1'b1; A = 8'h33; B = 8'h44; mode = 1'b1;
    @(negedge clk);
    A = 8'h55; B = 8'h66; mode = 1'b0;
    @(negedge clk);
    inValid = 1'b0;
    #1 rstN = 1'b0;
    #1;
    chk("mrst_outValid", 64'(outValid), 64'(0));
    chk("mrst_inReady", 64'(inReady), 64'(1));
    chk_stats("mrst", 0, 0, 0);
    @(negedge clk);
    rstN = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1 chk("mrst_stale", 64'(outValid), 64'(0));
    end

    // statistics clear coinciding with a d=2 approximate transfer
    send_one(8'h0D, 8'h17, 1'b1, s, om, lat);
    @(negedge clk);
    chk_stats("pre_clr", 1, 3, 3);
    send_one(8'h1B, 8'h6E, 1'b1, s, om, lat);
    statClr = 1'b1;
    @(negedge clk);
    statClr = 1'b0;
    chk_stats("clr", 0, 0, 0);
    send_one(8'hFF, 8'hFF, 1'b1, s, om, lat);
    chk("ff_sum", 64'(s), 64'h1FF);
    @(negedge clk);
    chk_stats("ff", 1, 1, 1);

    // random traffic with random backpressure and occasional clears
    pend = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      outReady = ($urandom_range(0, 3) != 0);
      statClr  = ($urandom_range(0, 19) == 0);
      if (!pend && $urandom_range(0, 3) != 0) begin
        A = 8'($urandom); B = 8'($urandom); mode = 1'($urandom_range(0, 1)); pend = 1;
      end
      inValid = pend;
      #1;
      if (inValid && inReady) pend = 0;
    end
    @(negedge clk);
    inValid = 1'b0; statClr = 1'b0; outReady = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain_empty", 64'(exp_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
